// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin packet arbiter and frame pacer sharing one UART TX.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LOCK_TO = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [13:0]              baud_div,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_transmit,
    output logic [7:0]               tx_data,
    output logic [13:0]              tx_baudrate,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);
    localparam int c_ID_W  = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(LOCK_TO + 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_TO - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCEPT = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_ID_W-1:0]  r_grant;
    logic [c_ID_W-1:0]  r_rr_ptr;
    logic [c_ID_W-1:0]  w_winner;
    logic               r_lock;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic [17:0]        r_timer;
    logic [17:0]        w_frame_m1;
    logic               w_any_valid;
    logic               w_hs;
    logic               w_sel_last;
    logic [7:0]         w_sel_data;
    logic               w_lock_expired;
    logic               w_timer_done;
    int                 w_dist;
    int                 w_best;

    // Frame = 10 bit periods plus 2 idle cycles; timer holds F-1.
    assign w_frame_m1     = 18'(baud_div) * 18'd10 + 18'd11;
    assign w_any_valid    = |req_valid;
    assign w_hs           = |(req_valid & req_ready);
    assign w_lock_expired = (r_lock_cnt == c_LOCK_LAST);
    assign w_timer_done   = (r_timer <= 18'd1);
    assign grant_id       = r_grant;

    // Winner is the valid requester at the smallest distance above rr_ptr.
    always_comb begin
        w_winner = r_rr_ptr;
        w_best   = N_REQ;
        w_dist   = 0;
        for (int j = 0; j < N_REQ; j++) begin
            w_dist = (j + 2 * N_REQ - 1 - int'(r_rr_ptr)) % N_REQ;
            if (req_valid[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = c_ID_W'(j);
            end
        end
    end

    always_comb begin
        w_sel_data = 8'h00;
        w_sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == c_ID_W'(i)) begin
                w_sel_data = req_data[8*i +: 8];
                w_sel_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any_valid) begin
                    w_next_state = c_ACCEPT;
                end
            end
            c_ACCEPT: begin
                if (w_hs) begin
                    w_next_state = c_WAIT;
                end else if (w_lock_expired) begin
                    w_next_state = c_IDLE;
                end
            end
            c_WAIT: begin
                if (w_timer_done) begin
                    w_next_state = r_lock ? c_ACCEPT : c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (r_state == c_ACCEPT) && (r_grant == c_ID_W'(i));
        end
        busy = (r_state != c_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant     <= '0;
            r_rr_ptr    <= c_ID_W'(N_REQ - 1);
            r_lock      <= 1'b0;
            r_lock_cnt  <= '0;
            r_timer     <= '0;
            tx_transmit <= 1'b0;
            tx_data     <= 8'h00;
            tx_baudrate <= 14'd0;
        end else begin
            tx_transmit <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any_valid) begin
                        r_grant    <= w_winner;
                        r_rr_ptr   <= w_winner;
                        r_lock     <= 1'b1;
                        r_lock_cnt <= '0;
                    end
                end
                c_ACCEPT: begin
                    if (w_hs) begin
                        tx_data     <= w_sel_data;
                        tx_baudrate <= baud_div;
                        tx_transmit <= 1'b1;
                        r_timer     <= w_frame_m1;
                        if (w_sel_last) begin
                            r_lock <= 1'b0;
                        end
                    end else if (w_lock_expired) begin
                        r_lock     <= 1'b0;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                c_WAIT: begin
                    if (w_timer_done) begin
                        if (r_lock) begin
                            r_lock_cnt <= '0;
                        end
                    end else begin
                        r_timer <= r_timer - 18'd1;
                    end
                end
                default: begin
                    r_lock <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
